// File: rtl/maple_pkg.sv
// Purpose : shared FSM state encoding and line-level marker constants for the Maple frame decoder.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
package maple_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_PHASE1 = 3'd2,
        ST_PHASE2 = 3'd3,
        ST_END    = 3'd4
    } state_t;

    // Start pattern: SDCKA falls while SDCKB is high, then SDCKB pulses while SDCKA is low.
    localparam logic START_B_LVL = 1'b1;
    localparam logic START_A_LVL = 1'b0;

    // End pattern: SDCKB falls while SDCKA is high (only meaningful in PHASE1).
    localparam logic END_A_LVL = 1'b1;

endpackage

// File: rtl/maple_word_fifo.sv
// Purpose : synchronous word FIFO with full/empty flags and a "set flag on tail entry" hook.
// Latency : a write is visible on rd_data/!empty one clk later; read data comes straight from flops.
// Backpressure: a write while full is refused unless a pop happens in the same clk.
// Ports   : clk/reset; wr_en/wr_data push; rd_en pop (ignored when empty); tail_flag_set sets
//           bit 0 of the most recently written entry if still resident; rd_data/full/empty status.
module maple_word_fifo
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic             tail_flag_set,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW-1:0]    tail_idx;
    logic             do_wr;
    logic             do_rd;
    logic             tail_popped;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_rd    = rd_en && !empty;
    assign do_wr    = wr_en && (!full || do_rd);
    assign tail_idx = wr_ptr[AW-1:0] - AW'(1);
    // The tail is being read out this clk when it is also the head.
    assign tail_popped = do_rd && (tail_idx == rd_ptr[AW-1:0]);

    // Zero when empty so the output bus is quiet between words.
    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_wr) begin
                mem[wr_ptr[AW-1:0]] <= wr_data;
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
            // tail_idx never equals the write slot while non-empty, so no write conflict.
            if (tail_flag_set && !empty && !tail_popped) begin
                mem[tail_idx][0] <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/maple_frame_decoder.sv
// Purpose : decodes Maple bus frames (start pattern, 2-phase data, end pattern) into packed words.
// Latency : completed word written to the FIFO 1 clk after its last bit; out_valid 1 clk after that.
// Backpressure: out_valid/out_ready; words arriving at a full FIFO are dropped and flag err_overflow.
// Ports   : clk/reset; sdck{a,b}_{data,posedge,negedge} synchronised line levels and edge strobes;
//           out_data/out_valid/out_ready/out_last/out_bytes word stream; frame_done pulse,
//           crc_ok (held until next frame start), sticky err_overflow / err_align.
module maple_frame_decoder
    import maple_pkg::*;
#(
    parameter int WORD_BYTES   = 4,
    parameter int FIFO_DEPTH   = 8,
    parameter int START_PULSES = 4
)
(
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          sdcka_data,
    input  logic                          sdcka_posedge,
    input  logic                          sdcka_negedge,
    input  logic                          sdckb_data,
    input  logic                          sdckb_posedge,
    input  logic                          sdckb_negedge,
    output logic [8*WORD_BYTES-1:0]       out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_last,
    output logic [$clog2(WORD_BYTES+1)-1:0] out_bytes,
    output logic                          frame_done,
    output logic                          crc_ok,
    output logic                          err_overflow,
    output logic                          err_align
);

    localparam int WW = 8 * WORD_BYTES;
    localparam int BW = $clog2(WORD_BYTES + 1);
    localparam int CW = $clog2(START_PULSES + 2);
    // FIFO entry layout: {word, byte count, last}; last sits in bit 0 for the tail-flag hook.
    localparam int EW = WW + BW + 1;

    state_t          state;
    state_t          state_nxt;
    logic            open_frame;
    logic            cnt_inc;
    logic            shift_en;
    logic            shift_bit;
    logic            end_mark;
    logic            close_frame;

    logic [CW-1:0]   start_cnt;
    logic [2:0]      bit_cnt;
    logic [7:0]      byte_sr;
    logic [WW-1:0]   word_buf;
    logic [BW-1:0]   byte_idx;
    logic [7:0]      crc;
    logic            frame_word;

    logic            push_vld;
    logic [EW-1:0]   push_dat;
    logic            mark_vld;

    logic [7:0]      new_byte;
    logic            byte_done;
    logic            word_done;
    logic [WW-1:0]   word_nxt;

    logic [EW-1:0]   fifo_rd_data;
    logic            fifo_full;
    logic            fifo_empty;
    logic            pop;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Each state honours only its own strobes; anything else in the same clk is ignored.
    always_comb begin
        state_nxt   = state;
        open_frame  = 1'b0;
        cnt_inc     = 1'b0;
        shift_en    = 1'b0;
        shift_bit   = 1'b0;
        end_mark    = 1'b0;
        close_frame = 1'b0;
        case (state)
            ST_IDLE: begin
                if (sdcka_negedge && sdckb_data == START_B_LVL) begin
                    open_frame = 1'b1;
                    state_nxt  = ST_START;
                end
            end
            ST_START: begin
                if (sdcka_posedge) begin
                    state_nxt = (start_cnt == CW'(START_PULSES)) ? ST_PHASE1 : ST_IDLE;
                end else if (sdckb_negedge && sdcka_data == START_A_LVL) begin
                    cnt_inc = 1'b1;
                end
            end
            ST_PHASE1: begin
                if (sdcka_negedge) begin
                    shift_en  = 1'b1;
                    shift_bit = sdckb_data;
                    state_nxt = ST_PHASE2;
                end else if (sdckb_negedge && sdcka_data == END_A_LVL) begin
                    end_mark  = 1'b1;
                    state_nxt = ST_END;
                end
            end
            ST_PHASE2: begin
                if (sdckb_negedge) begin
                    shift_en  = 1'b1;
                    shift_bit = sdcka_data;
                    state_nxt = ST_PHASE1;
                end
            end
            ST_END: begin
                if (sdckb_posedge) begin
                    close_frame = 1'b1;
                    state_nxt   = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------------- byte / word assembly
    assign new_byte  = {byte_sr[6:0], shift_bit};
    assign byte_done = shift_en && (bit_cnt == 3'd7);
    assign word_done = byte_done && (byte_idx == BW'(WORD_BYTES - 1));

    always_comb begin
        word_nxt = word_buf;
        for (int n = 0; n < WORD_BYTES; n++) begin
            if (byte_idx == BW'(n)) begin
                word_nxt[8*n +: 8] = new_byte;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            start_cnt    <= '0;
            bit_cnt      <= 3'd0;
            byte_sr      <= 8'd0;
            word_buf     <= '0;
            byte_idx     <= '0;
            crc          <= 8'd0;
            frame_word   <= 1'b0;
            push_vld     <= 1'b0;
            push_dat     <= '0;
            mark_vld     <= 1'b0;
            frame_done   <= 1'b0;
            crc_ok       <= 1'b0;
            err_overflow <= 1'b0;
            err_align    <= 1'b0;
        end else begin
            push_vld   <= 1'b0;
            mark_vld   <= 1'b0;
            frame_done <= 1'b0;

            if (open_frame) begin
                start_cnt  <= '0;
                bit_cnt    <= 3'd0;
                byte_sr    <= 8'd0;
                word_buf   <= '0;
                byte_idx   <= '0;
                crc        <= 8'd0;
                crc_ok     <= 1'b0;
                frame_word <= 1'b0;
            end

            // Saturates above START_PULSES so an over-long start pattern never wraps to a match.
            if (cnt_inc && start_cnt != '1) begin
                start_cnt <= start_cnt + CW'(1);
            end

            if (shift_en) begin
                byte_sr <= new_byte;
                bit_cnt <= bit_cnt + 3'd1;
            end

            if (byte_done) begin
                crc <= crc ^ new_byte;
                if (word_done) begin
                    push_vld   <= 1'b1;
                    push_dat   <= {word_nxt, BW'(WORD_BYTES), 1'b0};
                    word_buf   <= '0;
                    byte_idx   <= '0;
                    frame_word <= 1'b1;
                end else begin
                    word_buf <= word_nxt;
                    byte_idx <= byte_idx + BW'(1);
                end
            end

            if (end_mark) begin
                if (bit_cnt != 3'd0) begin
                    err_align <= 1'b1;
                end
                bit_cnt <= 3'd0;
                byte_sr <= 8'd0;
            end

            // frame_done rises together with push_vld, i.e. in the clk the flush enters the FIFO.
            if (close_frame) begin
                frame_done <= 1'b1;
                crc_ok     <= (crc == 8'd0);
                if (byte_idx != '0) begin
                    push_vld <= 1'b1;
                    push_dat <= {word_buf, byte_idx, 1'b1};
                    word_buf <= '0;
                    byte_idx <= '0;
                end else begin
                    // Nothing pending: tag this frame's last stored word, if it is still queued.
                    mark_vld <= frame_word;
                end
            end

            if (push_vld && fifo_full && !pop) begin
                err_overflow <= 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------- output buffering
    assign pop = out_valid && out_ready;

    maple_word_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk           (clk),
        .reset         (reset),
        .wr_en         (push_vld),
        .wr_data       (push_dat),
        .rd_en         (pop),
        .tail_flag_set (mark_vld),
        .rd_data       (fifo_rd_data),
        .full          (fifo_full),
        .empty         (fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign out_data  = fifo_rd_data[EW-1 -: WW];
    assign out_bytes = fifo_rd_data[BW:1];
    assign out_last  = fifo_rd_data[0];

endmodule

// File: tb/tb_maple_frame_decoder.sv
// Purpose : directed self-checking bench for maple_frame_decoder (WORD_BYTES=4, FIFO_DEPTH=8).
// Latency : line changes are applied one per two clks; outputs sampled 1 time unit after posedge.
// Backpressure: out_ready held low while a frame is sent, then raised to drain and record words.
module tb_maple_frame_decoder;

    localparam int WB = 4;
    localparam int FD = 8;
    localparam int SP = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          sdcka_data = 1'b1, sdcka_posedge = 1'b0, sdcka_negedge = 1'b0;
    logic          sdckb_data = 1'b1, sdckb_posedge = 1'b0, sdckb_negedge = 1'b0;
    logic [31:0]   out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          out_last;
    logic [2:0]    out_bytes;
    logic          frame_done, crc_ok, err_overflow, err_align;

    always #5 clk = ~clk;

    maple_frame_decoder #(
        .WORD_BYTES   (WB),
        .FIFO_DEPTH   (FD),
        .START_PULSES (SP)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .sdcka_data    (sdcka_data),
        .sdcka_posedge (sdcka_posedge),
        .sdcka_negedge (sdcka_negedge),
        .sdckb_data    (sdckb_data),
        .sdckb_posedge (sdckb_posedge),
        .sdckb_negedge (sdckb_negedge),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_last      (out_last),
        .out_bytes     (out_bytes),
        .frame_done    (frame_done),
        .crc_ok        (crc_ok),
        .err_overflow  (err_overflow),
        .err_align     (err_align)
    );

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------------------------------------------------------- output monitor
    typedef struct packed {
        logic [31:0] dat;
        logic [2:0]  nb;
        logic        last;
    } word_t;

    word_t rx_q[$];
    int    fd_cnt = 0;
    logic  crc_at_fd = 1'b0;

    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid && out_ready) rx_q.push_back(word_t'({out_data, out_bytes, out_last}));
            if (frame_done) begin
                fd_cnt++;
                crc_at_fd = crc_ok;
            end
        end
    end

    // ---------------------------------------------------------------- line drivers
    logic a_l = 1'b1;
    logic b_l = 1'b1;

    task automatic line(input logic a, input logic b);
        @(posedge clk); #1;
        sdcka_posedge = a & ~a_l;
        sdcka_negedge = ~a & a_l;
        sdckb_posedge = b & ~b_l;
        sdckb_negedge = ~b & b_l;
        sdcka_data = a;
        sdckb_data = b;
        a_l = a;
        b_l = b;
        @(posedge clk); #1;
        sdcka_posedge = 1'b0;
        sdcka_negedge = 1'b0;
        sdckb_posedge = 1'b0;
        sdckb_negedge = 1'b0;
    endtask

    // Raises SDCKB then SDCKA; only rising edges, so nothing opens a frame from IDLE.
    task automatic restore_idle();
        if (!b_l) line(a_l, 1'b1);
        if (!a_l) line(1'b1, 1'b1);
    endtask

    task automatic send_start(input int pulses);
        line(1'b0, 1'b1);
        for (int i = 0; i < pulses; i++) begin
            line(1'b0, 1'b0);
            line(1'b0, 1'b1);
        end
        line(1'b1, 1'b1);
    endtask

    // PHASE1 bit: SDCKA falls with data on SDCKB. From a=1,b=1,d=0 both lines fall together.
    task automatic bit_p1(input logic d);
        if (!a_l) begin
            line(1'b0, d);
            line(1'b1, d);
        end else if (b_l != d && d) begin
            line(1'b1, 1'b1);
        end
        line(1'b0, d);
    endtask

    // PHASE2 bit: SDCKB falls with data on SDCKA.
    task automatic bit_p2(input logic d);
        if (!b_l) line(a_l, 1'b1);
        if (a_l != d) line(d, 1'b1);
        line(d, 1'b0);
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 1; i -= 2) begin
            bit_p1(v[i]);
            bit_p2(v[i-1]);
        end
    endtask

    task automatic send_end();
        if (!a_l) line(1'b1, b_l);
        if (!b_l) line(1'b1, 1'b1);
        line(1'b1, 1'b0);
        line(1'b1, 1'b1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        rx_q.delete();
        @(posedge clk); #1;
        out_ready = 1'b1;
        repeat (FD + 4) @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_valid"}, out_valid, 1'b0);
        check({tag, "_data"},  out_data, 32'h0);
        check({tag, "_last"},  out_last, 1'b0);
        check({tag, "_bytes"}, out_bytes, 3'd0);
        check({tag, "_fdone"}, frame_done, 1'b0);
        check({tag, "_crc"},   crc_ok, 1'b0);
        check({tag, "_ovf"},   err_overflow, 1'b0);
        check({tag, "_aln"},   err_align, 1'b0);
    endtask

    int n_last;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("rst0");
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // 0x12,0x34,0x56,0x70: XOR is zero, one full word tagged last after the fact.
        send_start(SP);
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h70);
        send_end();
        check("t1_valid", out_valid, 1'b1);
        check("t1_data",  out_data, 32'h70563412);
        check("t1_last",  out_last, 1'b1);
        check("t1_bytes", out_bytes, 3'd4);
        check("t1_fd",    fd_cnt, 1);
        check("t1_crc",   crc_at_fd, 1'b1);
        drain();
        check("t1_nwords", rx_q.size(), 1);

        // Six bytes 01..06: XOR 0x07, words of 4 and 2 bytes.
        send_start(SP);
        for (int i = 1; i <= 6; i++) send_byte(8'(i));
        send_end();
        check("t2_fd",  fd_cnt, 2);
        check("t2_crc", crc_at_fd, 1'b0);
        drain();
        check("t2_nwords", rx_q.size(), 2);
        if (rx_q.size() == 2) begin
            check("t2_w0_data",  rx_q[0].dat, 32'h04030201);
            check("t2_w0_bytes", rx_q[0].nb, 3'd4);
            check("t2_w0_last",  rx_q[0].last, 1'b0);
            check("t2_w1_data",  rx_q[1].dat, 32'h00000605);
            check("t2_w1_bytes", rx_q[1].nb, 3'd2);
            check("t2_w1_last",  rx_q[1].last, 1'b1);
        end

        // Start with only 3 SDCKB pulses: abandoned.
        send_start(SP - 1);
        repeat (10) @(posedge clk);
        #1;
        check("t3_valid", out_valid, 1'b0);
        check("t3_fd",    fd_cnt, 2);

        // One byte 0xA5 plus 6 stray bits before the end marker.
        send_start(SP);
        send_byte(8'hA5);
        bit_p1(1'b1); bit_p2(1'b0); bit_p1(1'b1); bit_p2(1'b1); bit_p1(1'b0); bit_p2(1'b0);
        send_end();
        check("t4_align", err_align, 1'b1);
        check("t4_fd",    fd_cnt, 3);
        check("t4_crc",   crc_at_fd, 1'b0);
        check("t4_data",  out_data, 32'h000000A5);
        check("t4_bytes", out_bytes, 3'd1);
        check("t4_last",  out_last, 1'b1);
        drain();
        check("t4_nwords", rx_q.size(), 1);

        // Reset in the middle of a frame, then a clean frame.
        send_start(SP);
        send_byte(8'hAA); send_byte(8'hBB);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_reset_state("rst1");
        restore_idle();
        repeat (5) @(posedge clk);
        #1;
        check("t5_fd_none", fd_cnt, 3);
        send_start(SP);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h44); send_byte(8'h77);
        send_end();
        check("t5_data",  out_data, 32'h77442211);
        check("t5_last",  out_last, 1'b1);
        check("t5_bytes", out_bytes, 3'd4);
        check("t5_fd",    fd_cnt, 4);
        check("t5_crc",   crc_at_fd, 1'b1);
        drain();
        check("t5_nwords", rx_q.size(), 1);

        // 36 bytes (9 words) into an 8-deep FIFO with out_ready low.
        send_start(SP);
        for (int k = 0; k < 36; k++) send_byte(8'(k));
        send_end();
        check("t6_ovf",   err_overflow, 1'b1);
        check("t6_head",  out_data, 32'h03020100);
        check("t6_fd",    fd_cnt, 5);
        check("t6_crc",   crc_at_fd, 1'b1);
        check("t6_align", err_align, 1'b0);
        drain();
        check("t6_nwords", rx_q.size(), FD);
        n_last = 0;
        foreach (rx_q[i]) begin
            check($sformatf("t6_w%0d_data", i), rx_q[i].dat,
                  {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)});
            if (rx_q[i].last) n_last++;
        end
        check("t6_nlast", n_last, 1);
        if (rx_q.size() == FD) check("t6_w7_last", rx_q[FD-1].last, 1'b1);

        // Only reset clears the sticky overflow flag.
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("rst2");
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
